ahb_sramc_gen2: RTL and testbench
=================================

AHB_SRAMC_GEN2 -- requirements
Module: ahb_sramc_gen2

Interface
REQ-001 Param DATA_W, default 32, AHB/SRAM data width; legal 32 or 64.
REQ-002 Param DEPTH, default 4096, SRAM words; power of two; SA_W = $clog2(DEPTH).
REQ-003 Param ADDR_W, default 32, haddr width.
REQ-004 Param RD_WAIT, default 0, extra read wait states; legal 0..3.
REQ-005 hclk  in  1  sole clock; all logic on rising edge.
REQ-006 hreset  in  1  synchronous, active-high reset.
REQ-007 hsel, hwrite, hready_in  in  1 each  AHB select, direction, bus ready.
REQ-008 htrans  in  2; hsize  in  3; hburst  in  3 (ignored, every beat carries its own address).
REQ-009 haddr  in  ADDR_W; hwdata  in  DATA_W.
REQ-010 hready_out  out  1; hresp  out  2 (00 OKAY, 01 ERROR); hrdata  out  DATA_W.
REQ-011 sram_cs, sram_we  out  1; sram_be  out  DATA_W/8; sram_addr  out  SA_W; sram_wdata  out  DATA_W.
REQ-012 sram_rdata  in  DATA_W; valid the cycle after a read strobe and held until the next sram_cs.

Function
REQ-013 Valid transfer = hsel & hready_in & htrans[1]; IDLE/BUSY, or hsel low, -> OKAY, zero wait, no SRAM access.
REQ-014 Address phase captured on valid transfer: hwrite, hsize, haddr; word index = haddr >> log2(DATA_W/8).
REQ-015 Error when: hsize > log2(DATA_W/8), haddr not hsize-aligned, or word index >= DEPTH; no SRAM access.
REQ-016 FSM states: IDLE, WR, RD_WAIT, RD_LAST, ERR1, ERR2.
REQ-017 IDLE/WR/RD_LAST/ERR2 accept a new transfer: error -> ERR1; write -> WR; read -> RD_WAIT; none -> IDLE.
REQ-018 WR: sram_cs=1, sram_we=1, sram_addr=captured index, sram_wdata=hwdata, sram_be from hsize/haddr lanes; hready_out=1 (zero-wait write).
REQ-019 RD_WAIT: sram_cs=1, sram_we=0, sram_be all ones in first cycle only; hready_out=0; stays 1+RD_WAIT cycles (counter), then RD_LAST.
REQ-020 RD_LAST: hrdata=sram_rdata, hready_out=1, hresp=OKAY; read latency = 2+RD_WAIT data-phase cycles.
REQ-021 ERR1: hready_out=0, hresp=01; ERR2: hready_out=1, hresp=01 (two-cycle AHB error).
REQ-022 hrdata = 0 in every state except RD_LAST.
REQ-023 Write data phase overlapping a read address phase: write completes, read issues next cycle; read returns the newly written data.
REQ-024 Back-to-back writes sustain one beat per cycle; back-to-back reads insert 1+RD_WAIT wait cycles each.
REQ-025 Narrow writes touch only addressed lanes; other lanes of the word are unchanged.
REQ-026 Address-phase sampling uses hready_in only; a transfer presented while hready_in=0 is ignored.

Reset
REQ-027 hreset high on a rising edge forces FSM to IDLE and clears wait counter and captured address phase.
REQ-028 Reset values: hready_out=1, hresp=00, hrdata=0, sram_cs=0, sram_we=0, sram_be=0, sram_addr=0, sram_wdata=0.
REQ-029 Reset mid-read or mid-error aborts the transfer; no SRAM strobe in the cycle reset is sampled high.

Structure
REQ-030 Package ahb_sramc_pkg holds htrans/hsize/hresp encodings and the FSM state enum.
REQ-031 Sub-module ahb_sramc_lane_dec: hsize + haddr low bits -> sram_be and size-error flag, parametrised by DATA_W.

Verification
REQ-032 DATA_W=32, RD_WAIT=0: write 0xA5A5_1234 to 0x10, read 0x10 -> hready_out low 1 cycle, hrdata 0xA5A5_1234.
REQ-033 Byte write 0xEE to 0x13 over 0x1122_3344, read word -> 0xEE22_3344, sram_be=4'b1000 on write.
REQ-034 DEPTH=4096: read 0x4000 -> ERR1 (hready_out 0, hresp 01) then ERR2 (hready_out 1, hresp 01), sram_cs never high.
REQ-035 RD_WAIT=3, DATA_W=64: read -> 4 low hready_out cycles, hsize=3 accepted, hsize=2 at haddr 0x2 -> error.
REQ-036 Write 0x1 to 0x0 then read 0x0 back-to-back -> 0x1 returned; hreset asserted during RD_WAIT -> next cycle hready_out=1, hrdata=0, state IDLE.

Source files
------------

// File: rtl/ahb_sramc_pkg.sv
// Shared encodings for the AHB-to-SRAM controller.
//   htrans / hsize / hresp codes and the controller FSM state type.
package ahb_sramc_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdWait,
    StRdLast,
    StErr1,
    StErr2
  } state_e;

endpackage

// File: rtl/ahb_sramc_lane_dec.sv
// Byte-lane decoder.
//   i_hsize    : AHB transfer size
//   i_addr_lo  : byte offset of haddr within one data word
//   o_be       : byte enables of the lanes the transfer touches
//   o_size_err : size wider than the bus, or address not size-aligned
module ahb_sramc_lane_dec #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]                   i_hsize,
  input  logic [$clog2(DATA_W/8)-1:0]  i_addr_lo,
  output logic [DATA_W/8-1:0]          o_be,
  output logic                         o_size_err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LB    = $clog2(BYTES);

  logic w_too_big;
  logic w_misalign;

  always_comb begin
    w_too_big  = (i_hsize > 3'(LB));
    w_misalign = 1'b0;
    for (int unsigned j = 0; j < LB; j++) begin
      if ((j < 32'(i_hsize)) && i_addr_lo[j]) w_misalign = 1'b1;
    end
    o_be = '0;
    if (!w_too_big) begin
      // A lane is enabled when it falls in the same size-aligned group as the address.
      for (int unsigned i = 0; i < BYTES; i++) begin
        o_be[i] = ((i >> i_hsize) == (32'(i_addr_lo) >> i_hsize));
      end
    end
    o_size_err = w_too_big | w_misalign;
  end

endmodule

// File: rtl/ahb_sramc_gen2.sv
// AHB-Lite slave in front of a single-port synchronous SRAM.
//   AHB side : hsel/hwrite/hready_in/htrans/hsize/hburst/haddr/hwdata in,
//              hready_out/hresp/hrdata out. Zero-wait writes, 1+RD_WAIT wait reads,
//              two-cycle ERROR response for bad size/alignment/range.
//   SRAM side: sram_cs/sram_we/sram_be/sram_addr/sram_wdata out, sram_rdata in
//              (valid the cycle after a read strobe, held until the next strobe).
module ahb_sramc_gen2
  import ahb_sramc_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RD_WAIT = 0
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic                      hwrite,
  input  logic                      hready_in,
  input  logic [1:0]                htrans,
  input  logic [2:0]                hsize,
  input  logic [2:0]                hburst,
  input  logic [ADDR_W-1:0]         haddr,
  input  logic [DATA_W-1:0]         hwdata,
  output logic                      hready_out,
  output logic [1:0]                hresp,
  output logic [DATA_W-1:0]         hrdata,
  output logic                      sram_cs,
  output logic                      sram_we,
  output logic [DATA_W/8-1:0]       sram_be,
  output logic [$clog2(DEPTH)-1:0]  sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  input  logic [DATA_W-1:0]         sram_rdata
);

  localparam int unsigned BYTES    = DATA_W / 8;
  localparam int unsigned LB       = $clog2(BYTES);
  localparam int unsigned SA_W     = $clog2(DEPTH);
  localparam logic [1:0]  LAST_CNT = 2'(RD_WAIT);

  // Bursts carry a full address per beat and NONSEQ/SEQ are treated alike.
  logic w_unused;
  assign w_unused = ^hburst ^ htrans[0];

  logic             w_valid;
  logic             w_size_err;
  logic             w_range_err;
  logic             w_err;
  logic [BYTES-1:0] w_be;
  logic [SA_W-1:0]  w_idx;

  assign w_valid = hsel & hready_in & htrans[1];
  assign w_idx   = haddr[SA_W+LB-1:LB];

  if (ADDR_W > SA_W + LB) begin : g_range
    assign w_range_err = |haddr[ADDR_W-1:SA_W+LB];
  end else begin : g_no_range
    assign w_range_err = 1'b0;
  end

  assign w_err = w_size_err | w_range_err;

  ahb_sramc_lane_dec #(
    .DATA_W(DATA_W)
  ) u_lane_dec (
    .i_hsize   (hsize),
    .i_addr_lo (haddr[LB-1:0]),
    .o_be      (w_be),
    .o_size_err(w_size_err)
  );

  state_e           r_state;
  logic [1:0]       r_cnt;
  logic             r_hready;
  logic [1:0]       r_hresp;
  logic             r_cs;
  logic             r_we;
  logic [BYTES-1:0] r_be;
  logic [SA_W-1:0]  r_sa;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
      r_cs     <= 1'b0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_sa     <= '0;
    end else begin
      // SRAM strobes last a single cycle unless re-armed below.
      r_cs <= 1'b0;
      r_we <= 1'b0;
      r_be <= '0;
      r_sa <= '0;
      unique case (r_state)
        StRdWait: begin
          if (r_cnt == LAST_CNT) begin
            r_state  <= StRdLast;
            r_hready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        StErr1: begin
          r_state  <= StErr2;
          r_hready <= 1'b1;
        end
        default: begin
          // IDLE, WR, RD_LAST and ERR2 end a data phase and may take a new address phase.
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
          r_cnt    <= '0;
          if (!w_valid) begin
            r_state <= StIdle;
          end else if (w_err) begin
            r_state  <= StErr1;
            r_hready <= 1'b0;
            r_hresp  <= HRESP_ERROR;
          end else if (hwrite) begin
            r_state <= StWr;
            r_cs    <= 1'b1;
            r_we    <= 1'b1;
            r_be    <= w_be;
            r_sa    <= w_idx;
          end else begin
            r_state  <= StRdWait;
            r_hready <= 1'b0;
            r_cs     <= 1'b1;
            r_be     <= '1;
            r_sa     <= w_idx;
          end
        end
      endcase
    end
  end

  assign hready_out = r_hready;
  assign hresp      = r_hresp;
  assign hrdata     = (r_state == StRdLast) ? sram_rdata : '0;
  // Suppress the strobe in the very cycle a reset is being sampled.
  assign sram_cs    = r_cs & ~hreset;
  assign sram_we    = r_we & ~hreset;
  assign sram_be    = r_be;
  assign sram_addr  = r_sa;
  assign sram_wdata = (r_state == StWr) ? hwdata : '0;

endmodule

// File: tb/tb_ahb_sramc_gen2.sv
// Bench for ahb_sramc_gen2: one 32-bit/zero-wait and one 64-bit/three-wait instance,
// each driven by randomized and directed AHB traffic and checked against a
// transaction-level model (byte-array memory plus a per-cycle response queue).
module tb_ahb_sramc_gen2;

  int n_run  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    bit          hr;
    logic [1:0]  resp;
    bit          cs;
    bit          we;
    logic [7:0]  be;
    int          idx;
    bit          rd;
    bit          wr;
    logic [63:0] wd;
  } exp_t;

  typedef struct {
    bit          sel;
    bit          write;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] wd;
  } tx_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e.hr = 1'b1; e.resp = 2'b00; e.cs = 1'b0; e.we = 1'b0; e.be = 8'h00;
    e.idx = 0; e.rd = 1'b0; e.wr = 1'b0; e.wd = 64'h0;
    return e;
  endfunction

  function automatic tx_t mk(input bit w, input logic [2:0] sz, input logic [31:0] a,
                             input logic [63:0] wd);
    tx_t t;
    t.sel = 1'b1; t.write = w; t.trans = 2'b10; t.size = sz; t.addr = a; t.wd = wd;
    return t;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int DW    = (g == 0) ? 32 : 64;
    localparam int RW    = (g == 0) ? 0 : 3;
    localparam int B     = DW / 8;
    localparam int LB    = (g == 0) ? 2 : 3;
    localparam int DEPTH = 4096;
    localparam int SA_W  = 12;

    logic            hreset, hsel, hwrite, hready_in;
    logic [1:0]      htrans;
    logic [2:0]      hsize, hburst;
    logic [31:0]     haddr;
    logic [DW-1:0]   hwdata, hrdata, sram_wdata, sram_rdata;
    logic            hready_out, sram_cs, sram_we;
    logic [1:0]      hresp;
    logic [B-1:0]    sram_be;
    logic [SA_W-1:0] sram_addr;

    ahb_sramc_gen2 #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .ADDR_W (32),
      .RD_WAIT(RW)
    ) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hsel      (hsel),
      .hwrite    (hwrite),
      .hready_in (hready_in),
      .htrans    (htrans),
      .hsize     (hsize),
      .hburst    (hburst),
      .haddr     (haddr),
      .hwdata    (hwdata),
      .hready_out(hready_out),
      .hresp     (hresp),
      .hrdata    (hrdata),
      .sram_cs   (sram_cs),
      .sram_we   (sram_we),
      .sram_be   (sram_be),
      .sram_addr (sram_addr),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
    );

    // SRAM macro behaviour.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge hclk) begin
      if (sram_cs) begin
        if (sram_we) begin
          for (int i = 0; i < B; i++) begin
            if (sram_be[i]) mem[sram_addr][8*i+:8] <= sram_wdata[8*i+:8];
          end
        end else begin
          sram_rdata <= mem[sram_addr];
        end
      end
    end

    // Reference model: byte image of the 16 words under test and expected per-cycle response.
    logic [7:0]  mb [0:16*B-1];
    exp_t        q[$];
    int          lowcnt, errlo, errhi;
    bit          cs_seen;
    logic [63:0] last_rd;
    logic [7:0]  last_be;

    function automatic logic [63:0] model_word(input int idx);
      logic [63:0] w;
      w = 64'h0;
      for (int i = 0; i < B; i++) w[8*i+:8] = mb[idx*B+i];
      return w;
    endfunction

    function automatic tx_t rand_tx();
      tx_t t;
      int  sz, off, r;
      t.sel = ($urandom_range(7) != 0);
      r = int'($urandom_range(9));
      t.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
      t.write = ($urandom_range(1) == 1);
      sz = ($urandom_range(9) == 0) ? int'($urandom_range(7)) : int'($urandom_range(LB));
      t.size = 3'(sz);
      if (sz <= LB && $urandom_range(7) != 0) off = (int'($urandom_range(B-1)) >> sz) << sz;
      else off = int'($urandom_range(B-1));
      t.addr = 32'(int'($urandom_range(15)) * B + off);
      if ($urandom_range(15) == 0) t.addr = t.addr + 32'(DEPTH * B);
      t.wd = {$urandom, $urandom};
      return t;
    endfunction

    task automatic drive(input tx_t t, input bit rdy);
      hsel = t.sel; hwrite = t.write; htrans = t.trans; hsize = t.size; haddr = t.addr;
      hburst = 3'($urandom_range(7));
      hready_in = rdy;
    endtask

    task automatic present(input tx_t t);
      int   idx, off, sz;
      bit   err;
      exp_t e;
      drive(t, 1'b1);
      if (t.sel && t.trans[1]) begin
        sz  = int'(t.size);
        idx = int'(t.addr / B);
        off = int'(t.addr % B);
        err = (sz > LB) || ((t.addr % (32'd1 << sz)) != 0) || (idx >= DEPTH);
        e = idle_e();
        if (err) begin
          e.hr = 1'b0; e.resp = 2'b01; q.push_back(e);
          e.hr = 1'b1; q.push_back(e);
        end else if (t.write) begin
          e.cs = 1'b1; e.we = 1'b1; e.wr = 1'b1; e.idx = idx; e.wd = t.wd;
          for (int i = 0; i < B; i++) e.be[i] = (i >= off) && (i < off + (1 << sz));
          q.push_back(e);
        end else begin
          e.hr = 1'b0; e.cs = 1'b1; e.idx = idx;
          for (int i = 0; i < B; i++) e.be[i] = 1'b1;
          q.push_back(e);
          e.cs = 1'b0; e.be = 8'h00;
          repeat (RW) q.push_back(e);
          e.hr = 1'b1; e.rd = 1'b1; q.push_back(e);
        end
      end
    endtask

    // One bus cycle: check this cycle's outputs, supply write data, present the next
    // address phase (mode 0 idle, 1 directed, 2 random) when the data phase ends.
    task automatic step(input int mode, input tx_t d, output bit took);
      exp_t        e;
      tx_t         t;
      bit          was_idle;
      logic [63:0] wexp;
      took = 1'b0;
      @(negedge hclk);
      was_idle = (q.size() == 0);
      e = was_idle ? idle_e() : q.pop_front();
      chk($sformatf("c%0d hready_out", g), 64'(hready_out), 64'(e.hr));
      chk($sformatf("c%0d hresp", g), 64'(hresp), 64'(e.resp));
      chk($sformatf("c%0d hrdata", g), 64'(hrdata), e.rd ? model_word(e.idx) : 64'h0);
      chk($sformatf("c%0d sram_cs", g), 64'(sram_cs), 64'(e.cs));
      if (e.cs) begin
        chk($sformatf("c%0d sram_we", g), 64'(sram_we), 64'(e.we));
        chk($sformatf("c%0d sram_be", g), 64'(sram_be), 64'(e.be));
        chk($sformatf("c%0d sram_addr", g), 64'(sram_addr), 64'(e.idx));
      end
      if (!hready_out) lowcnt++;
      if (sram_cs) cs_seen = 1'b1;
      if (hresp == 2'b01) begin
        if (hready_out) errhi++;
        else errlo++;
      end
      if (e.rd) last_rd = 64'(hrdata);
      if (sram_cs && sram_we) last_be = 8'(sram_be);
      if (e.wr) begin
        hwdata = e.wd[DW-1:0];
        for (int i = 0; i < B; i++) if (e.be[i]) mb[e.idx*B+i] = e.wd[8*i+:8];
      end else begin
        hwdata = DW'({$urandom, $urandom});
      end
      if (e.hr) begin
        if (mode == 1) begin
          t = d; took = 1'b1;
        end else if (mode == 2) begin
          t = rand_tx();
        end else begin
          t = rand_tx(); t.sel = 1'b0;
        end
        // Another slave stalling the bus: the presented transfer must be ignored.
        if (mode == 2 && was_idle && $urandom_range(7) == 0) drive(t, 1'b0);
        else present(t);
      end else begin
        drive(rand_tx(), 1'b0);
      end
      if (e.wr) begin
        #1;
        wexp = 64'h0;
        wexp[DW-1:0] = e.wd[DW-1:0];
        chk($sformatf("c%0d sram_wdata", g), 64'(sram_wdata), wexp);
      end
    endtask

    task automatic xfer(input tx_t d);
      bit took;
      int n;
      took = 1'b0;
      n = 0;
      while (!took && n < 20) begin
        step(1, d, took);
        n++;
      end
      if (!took) chk($sformatf("c%0d issue timeout", g), 64'd0, 64'd1);
    endtask

    task automatic drain();
      bit   tk;
      int   n;
      tx_t  d0;
      d0 = mk(1'b0, 3'd0, 32'h0, 64'h0);
      n = 0;
      do begin
        step(0, d0, tk);
        n++;
      end while (q.size() != 0 && n < 20);
      if (q.size() != 0) chk($sformatf("c%0d drain timeout", g), 64'd0, 64'd1);
    endtask

    task automatic reset_check(input string tag);
      chk($sformatf("c%0d %s hready_out", g, tag), 64'(hready_out), 64'd1);
      chk($sformatf("c%0d %s hresp", g, tag), 64'(hresp), 64'd0);
      chk($sformatf("c%0d %s hrdata", g, tag), 64'(hrdata), 64'd0);
      chk($sformatf("c%0d %s sram_cs", g, tag), 64'(sram_cs), 64'd0);
      chk($sformatf("c%0d %s sram_we", g, tag), 64'(sram_we), 64'd0);
      chk($sformatf("c%0d %s sram_be", g, tag), 64'(sram_be), 64'd0);
      chk($sformatf("c%0d %s sram_addr", g, tag), 64'(sram_addr), 64'd0);
      chk($sformatf("c%0d %s sram_wdata", g, tag), 64'(sram_wdata), 64'd0);
    endtask

    initial begin
      tx_t d0;
      bit  tk;
      d0 = mk(1'b0, 3'd0, 32'h0, 64'h0);
      d0.sel = 1'b0;
      for (int i = 0; i < 16 * B; i++) mb[i] = 8'h00;
      lowcnt = 0; errlo = 0; errhi = 0; cs_seen = 1'b0; last_rd = 64'h0; last_be = 8'h00;
      hreset = 1'b1;
      drive(d0, 1'b1);
      hwdata = DW'({$urandom, $urandom});
      repeat (3) @(negedge hclk);
      reset_check("reset");
      hreset = 1'b0;

      // Zero-fill the words under test with back-to-back full-width writes.
      lowcnt = 0;
      for (int i = 0; i < 16; i++) xfer(mk(1'b1, 3'(LB), 32'(i * B), 64'h0));
      drain();
      chk($sformatf("c%0d b2b write stalls", g), 64'(lowcnt), 64'd0);

      if (g == 0) begin
        lowcnt = 0;
        xfer(mk(1'b1, 3'd2, 32'h10, 64'hA5A5_1234));
        xfer(mk(1'b0, 3'd2, 32'h10, 64'h0));
        drain();
        chk("c0 read wait cycles", 64'(lowcnt), 64'd1);
        chk("c0 read 0x10", last_rd, 64'hA5A5_1234);

        xfer(mk(1'b1, 3'd2, 32'h10, 64'h1122_3344));
        xfer(mk(1'b1, 3'd0, 32'h13, 64'hEE00_0000));
        xfer(mk(1'b0, 3'd2, 32'h10, 64'h0));
        drain();
        chk("c0 byte write be", 64'(last_be), 64'h8);
        chk("c0 byte merge", last_rd, 64'hEE22_3344);

        cs_seen = 1'b0; errlo = 0; errhi = 0;
        xfer(mk(1'b0, 3'd2, 32'h4000, 64'h0));
        drain();
        chk("c0 range err low", 64'(errlo), 64'd1);
        chk("c0 range err high", 64'(errhi), 64'd1);
        chk("c0 range err cs", 64'(cs_seen), 64'd0);

        xfer(mk(1'b1, 3'd2, 32'h0, 64'h1));
        xfer(mk(1'b0, 3'd2, 32'h0, 64'h0));
        drain();
        chk("c0 w-then-r", last_rd, 64'h1);
      end else begin
        lowcnt = 0;
        xfer(mk(1'b1, 3'd3, 32'h8, 64'h0123_4567_89AB_CDEF));
        xfer(mk(1'b0, 3'd3, 32'h8, 64'h0));
        drain();
        chk("c1 read wait cycles", 64'(lowcnt), 64'd4);
        chk("c1 dword read", last_rd, 64'h0123_4567_89AB_CDEF);

        errlo = 0; errhi = 0;
        xfer(mk(1'b0, 3'd2, 32'h2, 64'h0));
        drain();
        chk("c1 align err low", 64'(errlo), 64'd1);
        chk("c1 align err high", 64'(errhi), 64'd1);
      end

      // Reset while the read is waiting on the SRAM.
      xfer(mk(1'b0, 3'(LB), 32'(3 * B), 64'h0));
      @(negedge hclk);
      hreset = 1'b1;
      drive(d0, 1'b1);
      #1;
      chk($sformatf("c%0d cs during reset", g), 64'(sram_cs), 64'd0);
      q.delete();
      @(negedge hclk);
      hreset = 1'b0;
      reset_check("mid-read reset");

      repeat (1500) step(2, d0, tk);
      drain();
      done_cnt++;
    end
  end

  initial begin
    fork
      wait (done_cnt == 2);
      begin
        #500_000;
        n_run++;
        n_fail++;
        $display("FAIL global timeout: done %0d of 2", done_cnt);
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
